// File: rtl/wr_ptr_handler_pkg.sv
// Shared FIFO defaults (fifo_defs) for the write- and read-side pointer handlers.
// Keep both sides built from these so their pointer widths always agree.
package wr_ptr_handler_pkg;

  localparam int DEF_PTR_WIDTH = 3;
  localparam int DEF_AF_MARGIN = 2;

endpackage

// File: rtl/wr_ptr_handler_if.sv
// Producer-facing bus of the write pointer handler: write request, synchronised
// read pointer and overflow clear in; pointers, strobe and status flags out.
interface wr_ptr_handler_if
  import wr_ptr_handler_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH
);

  logic                 i_en;
  logic [PTR_WIDTH:0]   i_g_rd_ptr;
  logic                 i_ovf_clr;
  logic [PTR_WIDTH:0]   o_b_wr_ptr;
  logic [PTR_WIDTH:0]   o_g_wr_ptr;
  logic                 o_mem_we;
  logic                 o_full;
  logic                 o_almost_full;
  logic [PTR_WIDTH:0]   o_wr_level;
  logic                 o_overflow;

  modport master (
    output i_en, i_g_rd_ptr, i_ovf_clr,
    input  o_b_wr_ptr, o_g_wr_ptr, o_mem_we, o_full, o_almost_full, o_wr_level, o_overflow
  );

  modport slave (
    input  i_en, i_g_rd_ptr, i_ovf_clr,
    output o_b_wr_ptr, o_g_wr_ptr, o_mem_we, o_full, o_almost_full, o_wr_level, o_overflow
  );

endinterface

// File: rtl/wr_ptr_handler_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at and above it. Reusable by the read-side handler.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/wr_ptr_handler.sv
// Write-domain pointer handler of an async FIFO: advances binary/Gray write
// pointers and derives full, almost-full, level and sticky overflow.
module wr_ptr_handler
  import wr_ptr_handler_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  wr_ptr_handler_if.slave bus
);

  localparam int                 AF_THRESH_I = (1 << PTR_WIDTH) - AF_MARGIN;
  localparam logic [PTR_WIDTH:0] AF_THRESH   = AF_THRESH_I[PTR_WIDTH:0];

  logic [PTR_WIDTH:0] r_b_wr_ptr;
  logic [PTR_WIDTH:0] r_g_wr_ptr;
  logic [PTR_WIDTH:0] r_wr_level;
  logic               r_full;
  logic               r_almost_full;
  logic               r_overflow;

  logic [PTR_WIDTH:0] w_nxt_b;
  logic [PTR_WIDTH:0] w_nxt_g;
  logic [PTR_WIDTH:0] w_rd_bin;
  logic [PTR_WIDTH:0] w_lvl_nxt;
  logic [PTR_WIDTH:0] w_full_cmp;
  logic               w_mem_we;
  logic               w_full_nxt;
  logic               w_af_nxt;
  logic               w_ovf_nxt;

  gray2bin #(
    .WIDTH (PTR_WIDTH + 1)
  ) u_gray2bin (
    .i_gray (bus.i_g_rd_ptr),
    .o_bin  (w_rd_bin)
  );

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  generate
    if (PTR_WIDTH == 1) begin : g_cmp_narrow
      assign w_full_cmp = ~bus.i_g_rd_ptr;
    end else begin : g_cmp_wide
      assign w_full_cmp = {~bus.i_g_rd_ptr[PTR_WIDTH:PTR_WIDTH-1],
                           bus.i_g_rd_ptr[PTR_WIDTH-2:0]};
    end
  endgenerate

  assign w_mem_we   = bus.i_en & ~r_full;
  assign w_nxt_b    = r_b_wr_ptr + {{PTR_WIDTH{1'b0}}, w_mem_we};
  assign w_nxt_g    = w_nxt_b ^ (w_nxt_b >> 1);
  assign w_full_nxt = (w_nxt_g == w_full_cmp);
  assign w_lvl_nxt  = w_nxt_b - w_rd_bin;
  assign w_af_nxt   = (w_lvl_nxt >= AF_THRESH);
  // Set has priority over clear so a blocked write is never lost.
  assign w_ovf_nxt  = (bus.i_en & r_full) | (r_overflow & ~bus.i_ovf_clr);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_b_wr_ptr    <= '0;
      r_g_wr_ptr    <= '0;
      r_wr_level    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_b_wr_ptr    <= w_nxt_b;
      r_g_wr_ptr    <= w_nxt_g;
      r_wr_level    <= w_lvl_nxt;
      r_full        <= w_full_nxt;
      r_almost_full <= w_af_nxt;
      r_overflow    <= w_ovf_nxt;
    end
  end

  assign bus.o_b_wr_ptr    = r_b_wr_ptr;
  assign bus.o_g_wr_ptr    = r_g_wr_ptr;
  assign bus.o_mem_we      = w_mem_we;
  assign bus.o_full        = r_full;
  assign bus.o_almost_full = r_almost_full;
  assign bus.o_wr_level    = r_wr_level;
  assign bus.o_overflow    = r_overflow;

endmodule

// File: tb/tb_wr_ptr_handler.sv
// Directed bench for wr_ptr_handler at PTR_WIDTH=3, AF_MARGIN=2: reset, fill,
// overflow/clear, read-side release, pointer wrap and async reset mid-fill.
module tb_wr_ptr_handler;

  logic i_clk;
  logic i_rstn;
  int   n_cmp;
  int   n_err;

  wr_ptr_handler_if #(.PTR_WIDTH(3)) bus_if ();

  wr_ptr_handler #(
    .PTR_WIDTH (3),
    .AF_MARGIN (2)
  ) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_b"},    32'(bus_if.o_b_wr_ptr),    32'd0);
    chk({tag, "_g"},    32'(bus_if.o_g_wr_ptr),    32'd0);
    chk({tag, "_full"}, 32'(bus_if.o_full),        32'd0);
    chk({tag, "_af"},   32'(bus_if.o_almost_full), 32'd0);
    chk({tag, "_lvl"},  32'(bus_if.o_wr_level),    32'd0);
    chk({tag, "_ovf"},  32'(bus_if.o_overflow),    32'd0);
  endtask

  initial begin
    logic [3:0] exp_b;
    n_cmp = 0;
    n_err = 0;
    i_rstn            = 1'b0;
    bus_if.i_en       = 1'b0;
    bus_if.i_g_rd_ptr = 4'd0;
    bus_if.i_ovf_clr  = 1'b0;

    // reset state and combinational strobe
    @(negedge i_clk);
    chk_zero("rst");
    chk("rst_we0", 32'(bus_if.o_mem_we), 32'd0);
    bus_if.i_en = 1'b1;
    #1;
    chk("rst_we1", 32'(bus_if.o_mem_we), 32'd1);
    bus_if.i_en = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;

    // fill 8 entries
    for (int k = 1; k <= 8; k++) begin
      bus_if.i_en = 1'b1;
      step();
      chk("fill_b",   32'(bus_if.o_b_wr_ptr),    32'(k));
      chk("fill_lvl", 32'(bus_if.o_wr_level),    32'(k));
      chk("fill_af",  32'(bus_if.o_almost_full), (k >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(bus_if.o_full),       (k == 8) ? 32'd1 : 32'd0);
    end
    chk("full_g", 32'(bus_if.o_g_wr_ptr), 32'b1100);

    // blocked write while full, en still high
    #1;
    chk("blk_we", 32'(bus_if.o_mem_we), 32'd0);
    step();
    chk("blk_b",   32'(bus_if.o_b_wr_ptr), 32'd8);
    chk("blk_g",   32'(bus_if.o_g_wr_ptr), 32'b1100);
    chk("blk_ovf", 32'(bus_if.o_overflow), 32'd1);
    bus_if.i_en = 1'b0;
    step();
    chk("ovf_sticky", 32'(bus_if.o_overflow), 32'd1);
    bus_if.i_en      = 1'b1;
    bus_if.i_ovf_clr = 1'b1;
    step();
    chk("ovf_setwins", 32'(bus_if.o_overflow), 32'd1);
    bus_if.i_en = 1'b0;
    step();
    chk("ovf_clr", 32'(bus_if.o_overflow), 32'd0);
    bus_if.i_ovf_clr = 1'b0;

    // read side advances by one
    bus_if.i_g_rd_ptr = 4'b0001;
    step();
    chk("rd_full", 32'(bus_if.o_full),     32'd0);
    chk("rd_lvl",  32'(bus_if.o_wr_level), 32'd7);
    chk("rd_af",   32'(bus_if.o_almost_full), 32'd1);
    bus_if.i_en = 1'b1;
    step();
    chk("refill_full", 32'(bus_if.o_full),     32'd1);
    chk("refill_b",    32'(bus_if.o_b_wr_ptr), 32'd9);
    chk("refill_g",    32'(bus_if.o_g_wr_ptr), 32'b1101);
    chk("refill_lvl",  32'(bus_if.o_wr_level), 32'd8);
    bus_if.i_en = 1'b0;

    // async reset mid-fill at level 5
    i_rstn            = 1'b0;
    bus_if.i_g_rd_ptr = 4'd0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus_if.i_en = 1'b1;
      step();
    end
    chk("mid_lvl", 32'(bus_if.o_wr_level), 32'd5);
    @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge i_clk);
    bus_if.i_en = 1'b0;
    i_rstn = 1'b1;

    // wrap with read pointer trailing by two
    exp_b = 4'd0;
    for (int k = 0; k < 20; k++) begin
      bus_if.i_en       = 1'b1;
      bus_if.i_g_rd_ptr = to_gray(exp_b - 4'd2);
      step();
      exp_b = exp_b + 4'd1;
      chk("wrap_b",    32'(bus_if.o_b_wr_ptr), 32'(exp_b));
      chk("wrap_g",    32'(bus_if.o_g_wr_ptr), 32'(to_gray(exp_b)));
      chk("wrap_full", 32'(bus_if.o_full),     32'd0);
      chk("wrap_lvl",  32'(bus_if.o_wr_level), 32'd3);
      if (k == 14) chk("wrap_g15", 32'(bus_if.o_g_wr_ptr), 32'b1000);
      if (k == 15) chk("wrap_g0",  32'(bus_if.o_g_wr_ptr), 32'b0000);
    end
    bus_if.i_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wr_ptr_handler.md
WR_PTR_HANDLER -- requirements
Module: wr_ptr_handler

Interface
REQ-001 Parameter PTR_WIDTH, default 3: address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits wide; legal range is PTR_WIDTH >= 1.
REQ-002 Parameter AF_MARGIN, default 2: almost-full threshold; legal range is 1 .. 2^PTR_WIDTH - 1.
REQ-003 i_clk  in  1  sole clock, write domain, rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_en  in  1  write request from the producer.
REQ-006 i_g_rd_ptr  in  PTR_WIDTH+1  Gray read pointer, already synchronised into the write domain.
REQ-007 i_ovf_clr  in  1  clears the sticky overflow flag.
REQ-008 o_b_wr_ptr  out  PTR_WIDTH+1  registered binary write pointer to the FIFO memory; the memory uses the low PTR_WIDTH bits as its address.
REQ-009 o_g_wr_ptr  out  PTR_WIDTH+1  registered Gray write pointer to the read-domain synchroniser.
REQ-010 o_mem_we  out  1  combinational memory write strobe.
REQ-011 o_full  out  1  registered full flag.
REQ-012 o_almost_full  out  1  registered almost-full flag.
REQ-013 o_wr_level  out  PTR_WIDTH+1  registered fill level as seen from the write domain.
REQ-014 o_overflow  out  1  sticky flag: a write was attempted while full.

Function
REQ-015 Accept condition: o_mem_we = i_en & ~o_full; a write is accepted in any cycle where o_mem_we = 1.
REQ-016 Next binary pointer: nxt_b = o_b_wr_ptr + o_mem_we, modulo 2^(PTR_WIDTH+1); it wraps from all-ones to 0 with no special handling.
REQ-017 Next Gray pointer: nxt_g = nxt_b ^ (nxt_b >> 1).
REQ-018 Full compare: full_nxt = (nxt_g == {~i_g_rd_ptr[PTR_WIDTH:PTR_WIDTH-1], i_g_rd_ptr[PTR_WIDTH-2:0]}); for PTR_WIDTH = 1 the compare value is ~i_g_rd_ptr.
REQ-019 Read-pointer conversion: rd_bin = Gray-to-binary of i_g_rd_ptr, computed combinationally.
REQ-020 Level: lvl_nxt = nxt_b - rd_bin, modulo 2^(PTR_WIDTH+1); the range is 0 .. 2^PTR_WIDTH.
REQ-021 Almost-full: af_nxt = (lvl_nxt >= 2^PTR_WIDTH - AF_MARGIN).
REQ-022 Register update: on every rising edge, o_b_wr_ptr, o_g_wr_ptr, o_full, o_almost_full and o_wr_level load nxt_b, nxt_g, full_nxt, af_nxt and lvl_nxt respectively.
REQ-023 Flag latency: all flags reflect the write that is accepted on the same edge, so o_full is high in the cycle after the write that fills the FIFO.
REQ-024 Read-side lag: a read-pointer advance that arrives on i_g_rd_ptr clears o_full and lowers o_wr_level at the next edge.
REQ-025 Pessimism: the flags SHALL never under-report fullness; they may over-report while i_g_rd_ptr lags, and this is by design.
REQ-026 Overflow set: o_overflow sets when i_en & o_full.
REQ-027 Overflow clear: o_overflow clears when i_ovf_clr = 1; if set and clear occur in the same cycle, set wins.
REQ-028 Blocked write: a write while full SHALL NOT change either pointer, and o_mem_we = 0 in that cycle.
REQ-029 Pointer stability: i_g_rd_ptr may change at any cycle, and o_g_wr_ptr changes by at most one bit per cycle.

Reset
REQ-030 While i_rstn = 0: o_b_wr_ptr = 0, o_g_wr_ptr = 0, o_full = 0, o_almost_full = 0, o_wr_level = 0, o_overflow = 0.
REQ-031 Reset takes effect asynchronously mid-operation; the first write is accepted on the first rising edge after deassertion.

Structure
REQ-032 Shared header fifo_defs holds the default PTR_WIDTH and AF_MARGIN, shared with the read-side handler.
REQ-033 Gray-to-binary conversion is a sub-module gray2bin, parameterised by width, purely combinational, and reusable by the read side.
REQ-034 All sequential logic sits in one always block sensitive to posedge i_clk and negedge i_rstn.

Verification (PTR_WIDTH = 3, AF_MARGIN = 2, i_g_rd_ptr = 0 unless stated)
REQ-035 Reset -> all outputs 0; o_mem_we = i_en.
REQ-036 Fill: 8 consecutive writes -> o_almost_full = 1 after the 6th write (level 6); o_full = 1 after the 8th write; o_b_wr_ptr = 8; o_g_wr_ptr = 4'b1100; o_wr_level = 8.
REQ-037 Write while full, then i_ovf_clr pulse -> pointers hold at 8, o_mem_we = 0, o_overflow = 1 until the clear, and 0 on the edge after the clear.
REQ-038 From full, i_g_rd_ptr = 4'b0001 (binary 1) -> next edge o_full = 0 and o_wr_level = 7; the next write sets o_full = 1 again.
REQ-039 Wrap: 20 writes with i_g_rd_ptr tracking the write pointer minus 2 -> o_b_wr_ptr goes 15 -> 0, o_g_wr_ptr goes 4'b1000 -> 4'b0000, o_full never asserts, o_wr_level stays at or below 3.
REQ-040 i_rstn pulsed low mid-fill at level 5 -> all outputs 0 immediately, without waiting for a clock edge.
